// File: rtl/wb_pipe_stage.sv
// Elastic MEM->WB writeback stage: a 2-entry skid buffer with a registered in_ready,
// synchronous flush and optional suppression of writes to x0.
module wb_pipe_stage #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter bit ZERO_SUPPRESS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              rf_we_d,
    input  logic [ADDR_W-1:0] rf_waddr_d,
    input  logic [DATA_W-1:0] rf_wdata_d,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              rf_we_q,
    output logic [ADDR_W-1:0] rf_waddr_q,
    output logic [DATA_W-1:0] rf_wdata_q,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_next;

    logic              in_ready_q;
    logic              main_we, skid_we;
    logic [ADDR_W-1:0] main_waddr, skid_waddr;
    logic [DATA_W-1:0] main_wdata, skid_wdata;

    logic in_fire, out_fire, cap_we;
    logic load_main_in, load_main_skid, load_skid;

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = (state != EMPTY) && out_ready;
    assign cap_we   = ZERO_SUPPRESS ? (rf_we_d && (rf_waddr_d != '0)) : rf_we_d;

    // Flush empties the stage and discards any input accepted in the same cycle.
    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_next   = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        state_next = FULL;
                        load_skid  = 1'b1;
                    end else if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (out_fire) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_next     = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // in_ready is derived from the next state so it leaves the stage as a flop output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_next;
            in_ready_q <= (state_next != FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_we    <= 1'b0;
            main_waddr <= '0;
            main_wdata <= '0;
            skid_we    <= 1'b0;
            skid_waddr <= '0;
            skid_wdata <= '0;
        end else begin
            if (load_main_in) begin
                main_we    <= cap_we;
                main_waddr <= rf_waddr_d;
                main_wdata <= rf_wdata_d;
            end else if (load_main_skid) begin
                main_we    <= skid_we;
                main_waddr <= skid_waddr;
                main_wdata <= skid_wdata;
            end
            if (load_skid) begin
                skid_we    <= cap_we;
                skid_waddr <= rf_waddr_d;
                skid_wdata <= rf_wdata_d;
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = (state != EMPTY);
    assign rf_we_q    = main_we && out_valid;
    assign rf_waddr_q = main_waddr;
    assign rf_wdata_q = main_wdata;
    assign occupancy  = 2'(state);

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Scoreboard bench for wb_pipe_stage: two instances (x0 suppression on and off) share stimulus,
// each with its own expected-entry queue drained by a negedge monitor.
module tb_wb_pipe_stage;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        rf_we_d;
    logic [4:0]  rf_waddr_d;
    logic [31:0] rf_wdata_d;

    logic        in_ready, out_valid, rf_we_q;
    logic [4:0]  rf_waddr_q;
    logic [31:0] rf_wdata_q;
    logic [1:0]  occupancy;

    logic        in_ready0, out_valid0, rf_we_q0;
    logic [4:0]  rf_waddr_q0;
    logic [31:0] rf_wdata_q0;
    logic [1:0]  occupancy0;

    int checks = 0;
    int errors = 0;

    entry_t exp_q1[$];
    entry_t exp_q0[$];

    always #5 clk = ~clk;

    wb_pipe_stage #(.DATA_W(32), .ADDR_W(5), .ZERO_SUPPRESS(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .rf_we_d(rf_we_d), .rf_waddr_d(rf_waddr_d), .rf_wdata_d(rf_wdata_d),
        .out_valid(out_valid), .out_ready(out_ready),
        .rf_we_q(rf_we_q), .rf_waddr_q(rf_waddr_q), .rf_wdata_q(rf_wdata_q),
        .occupancy(occupancy)
    );

    wb_pipe_stage #(.DATA_W(32), .ADDR_W(5), .ZERO_SUPPRESS(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0),
        .rf_we_d(rf_we_d), .rf_waddr_d(rf_waddr_d), .rf_wdata_d(rf_wdata_d),
        .out_valid(out_valid0), .out_ready(out_ready),
        .rf_we_q(rf_we_q0), .rf_waddr_q(rf_waddr_q0), .rf_wdata_q(rf_wdata_q0),
        .occupancy(occupancy0)
    );

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle of input; an entry is expected only if it will really be accepted.
    task automatic apply_stimulus(input logic v, input logic we, input logic [4:0] addr,
                                  input logic [31:0] data, input logic fl);
        entry_t e;
        in_valid   = v;
        rf_we_d    = we;
        rf_waddr_d = addr;
        rf_wdata_d = data;
        flush      = fl;
        e.waddr = addr;
        e.wdata = data;
        if (v && in_ready && !fl && !rst) begin
            e.we = we && (addr != 5'd0);
            exp_q1.push_back(e);
        end
        if (v && in_ready0 && !fl && !rst) begin
            e.we = we;
            exp_q0.push_back(e);
        end
    endtask

    task automatic check_state(input string tag, input logic [1:0] occ, input logic ir,
                               input logic ov);
        check_output({tag, "_occupancy"}, occupancy, occ);
        check_output({tag, "_in_ready"}, in_ready, ir);
        check_output({tag, "_out_valid"}, out_valid, ov);
        check_output({tag, "_occupancy_zs0"}, occupancy0, occ);
    endtask

    task automatic check_reset_values(input string tag);
        check_state(tag, 2'd0, 1'b1, 1'b0);
        check_output({tag, "_we_q"}, rf_we_q, 0);
        check_output({tag, "_waddr_q"}, rf_waddr_q, 0);
        check_output({tag, "_wdata_q"}, rf_wdata_q, 0);
    endtask

    // Monitor: every head consumption must match the oldest expected entry.
    always @(negedge clk) begin
        entry_t e;
        if (out_valid && out_ready) begin
            if (exp_q1.size() == 0) begin
                check_output("zs1_unexpected_head", out_valid, 0);
            end else begin
                e = exp_q1.pop_front();
                check_output("zs1_head_we", rf_we_q, e.we);
                check_output("zs1_head_waddr", rf_waddr_q, e.waddr);
                check_output("zs1_head_wdata", rf_wdata_q, e.wdata);
            end
        end
        if (out_valid0 && out_ready) begin
            if (exp_q0.size() == 0) begin
                check_output("zs0_unexpected_head", out_valid0, 0);
            end else begin
                e = exp_q0.pop_front();
                check_output("zs0_head_we", rf_we_q0, e.we);
                check_output("zs0_head_waddr", rf_waddr_q0, e.waddr);
                check_output("zs0_head_wdata", rf_wdata_q0, e.wdata);
            end
        end
        if (!out_valid) check_output("zs1_we_without_valid", rf_we_q, 0);
        if (!out_valid0) check_output("zs0_we_without_valid", rf_we_q0, 0);
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        rf_we_d = 1'b0; rf_waddr_d = '0; rf_wdata_d = '0;

        // Reset held for two cycles
        step();
        @(negedge clk);
        check_output("rst_we_q_during", rf_we_q, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("reset");

        // Streaming at full throughput
        out_ready = 1'b1;
        step(); apply_stimulus(1, 1, 5'd3, 32'h11, 0);
        step(); apply_stimulus(1, 1, 5'd4, 32'h22, 0);
        @(negedge clk); check_state("stream_a", 2'd1, 1'b1, 1'b1);
        step(); apply_stimulus(1, 1, 5'd5, 32'h33, 0);
        @(negedge clk); check_state("stream_b", 2'd1, 1'b1, 1'b1);
        step(); apply_stimulus(0, 0, 5'd0, 32'h0, 0);
        @(negedge clk); check_state("stream_c", 2'd1, 1'b1, 1'b1);
        step(); out_ready = 1'b0;
        @(negedge clk); check_state("stream_drained", 2'd0, 1'b1, 1'b0);

        // Back-pressure fills the skid register
        step(); apply_stimulus(1, 1, 5'd6, 32'h44, 0);
        step(); apply_stimulus(1, 1, 5'd7, 32'h55, 0);
        @(negedge clk); check_state("stall_one", 2'd1, 1'b1, 1'b1);
        step(); apply_stimulus(0, 0, 5'd0, 32'h0, 0);
        @(negedge clk); check_state("stall_full", 2'd2, 1'b0, 1'b1);
        step(); out_ready = 1'b1;
        step();
        @(negedge clk); check_state("stall_release", 2'd1, 1'b1, 1'b1);
        step();
        @(negedge clk); check_state("stall_empty", 2'd0, 1'b1, 1'b0);

        // x0 suppression, plus an ordinary we=0 entry
        step(); apply_stimulus(1, 1, 5'd0, 32'hDEAD, 0);
        step(); apply_stimulus(1, 0, 5'd9, 32'h99, 0);
        step(); apply_stimulus(0, 0, 5'd0, 32'h0, 0);
        step(); step();

        // Flush while full and stalled, with an input offered
        out_ready = 1'b0;
        step(); apply_stimulus(1, 1, 5'd10, 32'hAA, 0);
        step(); apply_stimulus(1, 1, 5'd11, 32'hBB, 0);
        step(); apply_stimulus(0, 0, 5'd0, 32'h0, 0);
        @(negedge clk); check_state("pre_flush", 2'd2, 1'b0, 1'b1);
        step(); apply_stimulus(1, 1, 5'd8, 32'h88, 1);
        exp_q1.delete(); exp_q0.delete();
        step(); apply_stimulus(0, 0, 5'd0, 32'h0, 0);
        @(negedge clk); check_state("flush_full", 2'd0, 1'b1, 1'b0);

        // Flush while one entry held and an input actually fires
        step(); apply_stimulus(1, 1, 5'd12, 32'hCC, 0);
        step(); apply_stimulus(1, 1, 5'd14, 32'hEE, 1);
        exp_q1.delete(); exp_q0.delete();
        step(); apply_stimulus(0, 0, 5'd0, 32'h0, 0);
        @(negedge clk); check_state("flush_one", 2'd0, 1'b1, 1'b0);
        out_ready = 1'b1;
        step(); step();

        // Reset while full with input offered
        out_ready = 1'b0;
        step(); apply_stimulus(1, 1, 5'd15, 32'h1515, 0);
        step(); apply_stimulus(1, 1, 5'd16, 32'h1616, 0);
        step(); apply_stimulus(1, 1, 5'd17, 32'h1717, 0);
        @(negedge clk); check_state("pre_reset", 2'd2, 1'b0, 1'b1);
        step();
        rst = 1'b1;
        apply_stimulus(1, 1, 5'd17, 32'h1717, 0);
        exp_q1.delete(); exp_q0.delete();
        step();
        rst = 1'b0;
        apply_stimulus(0, 0, 5'd0, 32'h0, 0);
        @(negedge clk); check_reset_values("mid_reset");

        // Normal operation resumes after reset
        out_ready = 1'b1;
        step(); apply_stimulus(1, 1, 5'd13, 32'h1234, 0);
        step(); apply_stimulus(0, 0, 5'd0, 32'h0, 0);
        for (int i = 0; i < 20; i++) begin
            if (exp_q1.size() == 0 && exp_q0.size() == 0) break;
            @(negedge clk);
        end
        step();
        check_output("zs1_leftover", exp_q1.size(), 0);
        check_output("zs0_leftover", exp_q0.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_pipe_stage.md
Name: wb_pipe_stage

Overview:
- Parametrised successor to the MEM/WB stage register.
- Elastic pipeline stage carrying the register-file writeback triple (we, waddr, wdata) between MEM and WB, with a valid/ready handshake.
- A 2-entry skid buffer sustains full throughput while keeping in_ready registered.
- Adds synchronous flush and optional suppression of writes to x0.

Parameters:
DATA_W, 32, width of rf_wdata.
ADDR_W, 5, width of rf_waddr.
ZERO_SUPPRESS, 1, when 1 a captured write with waddr==0 has its we bit cleared.

Ports:
clk  in  1  clock, all state updates on posedge.
rst  in  1  reset; synchronous, active-high.
flush  in  1  drop all buffered entries and any input offered this cycle.
in_valid  in  1  upstream entry valid.
in_ready  out  1  stage can accept; registered output.
rf_we_d  in  1  write enable of incoming entry.
rf_waddr_d  in  ADDR_W  destination register of incoming entry.
rf_wdata_d  in  DATA_W  write data of incoming entry.
out_valid  out  1  head entry valid.
out_ready  in  1  downstream accepts head.
rf_we_q  out  1  head write enable, forced 0 when out_valid=0.
rf_waddr_q  out  ADDR_W  head destination register.
rf_wdata_q  out  DATA_W  head write data.
occupancy  out  2  entries held: 0, 1 or 2.

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (the head, drives the outputs) and skid register.
- FSM states: EMPTY (occupancy 0), ONE (1), FULL (2).
- Outputs: out_valid = (state != EMPTY). in_ready = (state != FULL) and is registered, i.e. computed from next-state.
- Transitions, with rst=0 and flush=0:
  - EMPTY: in_fire -> ONE; main <= input.
  - ONE: in_fire & !out_fire -> FULL; skid <= input.
  - ONE: in_fire & out_fire -> ONE; main <= input.
  - ONE: !in_fire & out_fire -> EMPTY.
  - ONE: neither -> hold.
  - FULL: out_fire -> ONE; main <= skid. No input is accepted because in_ready=0.
  - FULL: !out_fire -> hold.
- Latency: 1 cycle from in_fire to the entry appearing at the head when the stage was empty.
- Ordering: strict FIFO order is preserved.
- Throughput: one entry per cycle while out_ready=1.
- x0 suppression: when ZERO_SUPPRESS=1, the stored we = rf_we_d & (rf_waddr_d != 0). waddr and wdata are still stored unchanged. When ZERO_SUPPRESS=0, we is stored as given.
- Payload registers update only on capture; they hold otherwise.
- Reset (rst=1 at posedge):
  - state = EMPTY, in_ready=1, out_valid=0, rf_we_q=0, rf_waddr_q=0, rf_wdata_q=0, occupancy=0.
  - Skid payload is cleared to 0.
  - rst has priority over flush and over all traffic.
- Flush (flush=1, rst=0):
  - next state = EMPTY and in_ready=1 next cycle.
  - Any in_fire in the same cycle is discarded.
  - An out_fire in the same cycle is still a legal consumption: downstream owns that entry. The stage has no further obligation for it.
  - Payload registers may retain stale values, but rf_we_q is 0 because out_valid=0.
- Invariant: rf_we_q is never 1 while out_valid=0.
- Simultaneous flush and stall: flush wins, and the stage empties.
- Reset or flush mid-operation: no partial entry survives, and no entry is duplicated.

Test Plan:
1. rst high for 2 cycles, then low -> out_valid=0, in_ready=1, occupancy=0, rf_wdata_q=0; rf_we_q=0 throughout.
2. Stream A(we=1,addr=3,data=0x11), B(we=1,addr=4,data=0x22), C(we=1,addr=5,data=0x33) on consecutive cycles, out_ready=1 -> head shows A, B, C on consecutive cycles starting 1 cycle after the first in_fire; occupancy stays 1; in_ready stays 1.
3. out_ready=0, offer D(addr=6,data=0x44) then E(addr=7,data=0x55) -> occupancy 1 then 2; in_ready=0 the cycle after E is captured. Raise out_ready -> outputs D then E; in_ready returns to 1 after D leaves.
4. Offer we=1, addr=0, data=0xDEAD with ZERO_SUPPRESS=1 -> head shows rf_we_q=0, rf_waddr_q=0, rf_wdata_q=0xDEAD. Rerun with ZERO_SUPPRESS=0 -> rf_we_q=1.
5. FULL state with out_ready=0; assert flush together with in_valid of F(addr=8) -> next cycle out_valid=0, occupancy=0, in_ready=1; F never appears at the head.
6. Assert rst while occupancy=2 and in_valid=1 -> next cycle all outputs at their reset values; the previously queued entries never appear at the head.
